// File: rtl/corr_mag_avg.sv
// corr_mag_avg: per-bin |corr|^2 averager for the PN correlator output.
// Squares each complex sample and accumulates it into bin (sample index mod len)
// over 2^LOG2_AVG PN periods. It then streams one averaged value per bin under
// AXI-stream backpressure. Bin phase is kept across dumps, so peaks stay put.
// Optional: define CORR_MAG_PEAK_EN to add o_peak_val / o_peak_idx, which give the
// largest dumped value and its bin.
module corr_mag_avg #(
    parameter int MAX_LEN  = 256,
    parameter int LOG2_AVG = 7,
    parameter int ACC_W    = 32 + LOG2_AVG
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_tdata,
    input  logic        i_tvalid,
    input  logic        i_tlast,
    output logic        i_tready,
    output logic [31:0] o_tdata,
    output logic        o_tvalid,
    output logic        o_tlast,
    input  logic        o_tready,
    input  logic        i_start,
    input  logic [8:0]  i_pnseq_length,
`ifdef CORR_MAG_PEAK_EN
    output logic [31:0] o_peak_val,
    output logic [8:0]  o_peak_idx,
`endif
    output logic        o_busy
);
    localparam int         AW        = $clog2(MAX_LEN);
    localparam logic [8:0] MAX_LEN_L = 9'(MAX_LEN);
    localparam logic [8:0] MIN_LEN   = 9'd7;

    typedef enum logic [1:0] {IDLE, ACCUM, DUMP, SYNC} state_t;

    // Exact I^2 + Q^2; the largest value (2^31 at I = Q = -32768) still fits in 32 bits.
    function automatic logic [31:0] mag_calc(input logic signed [15:0] re,
                                             input logic signed [15:0] im);
        logic signed [31:0] re_sq;
        logic signed [31:0] im_sq;
        re_sq = 32'(re) * 32'(re);
        im_sq = 32'(im) * 32'(im);
        return unsigned'(re_sq) + unsigned'(im_sq);
    endfunction

    // Divide by the number of averaged periods and truncate to the output width.
    function automatic logic [31:0] avg_scale(input logic [ACC_W-1:0] acc);
        return 32'(acc >> LOG2_AVG);
    endfunction

    state_t              state, state_nxt;
    logic [8:0]          len, bin, rd_ptr;
    logic [LOG2_AVG-1:0] per;
    logic [1:0]          drain;
    logic                len_ok, last_bin, sample_last, acc_take;
    logic                dump_go, dump_adv, dump_hs, dump_done;
    logic                vld_p1, first_p1;
    logic [31:0]         mag_p1;
    logic [AW-1:0]       bin_p1, rd_addr;
    logic [ACC_W-1:0]    ram_rd_p1;
    logic                rq_vld, rq_last;
    logic [ACC_W-1:0]    ram [MAX_LEN];
    logic                unused_tlast;

    assign unused_tlast = i_tlast;
    assign i_tready     = 1'b1;
    assign o_busy       = (state != IDLE);
    assign len_ok       = (i_pnseq_length >= MIN_LEN) && (i_pnseq_length <= MAX_LEN_L);
    assign last_bin     = (bin == len - 9'd1);
    assign sample_last  = i_tvalid && last_bin;
    assign acc_take     = (state == ACCUM) && i_tvalid && !i_start;
    assign dump_adv     = !o_tvalid || o_tready;
    assign dump_hs      = o_tvalid && o_tready;
    assign dump_done    = dump_hs && o_tlast;
    assign dump_go      = (state == DUMP) && (drain == 2'd2) && (rd_ptr < len);
    assign rd_addr      = (state == DUMP) ? rd_ptr[AW-1:0] : bin[AW-1:0];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; a start pulse overrides whatever the current state is doing.
    always_comb begin
        state_nxt = state;
        if (i_start) begin
            state_nxt = len_ok ? ACCUM : IDLE;
        end else begin
            case (state)
                ACCUM:   if (sample_last && (&per)) state_nxt = DUMP;
                DUMP:    if (dump_done) state_nxt = sample_last ? ACCUM : SYNC;
                SYNC:    if (sample_last) state_nxt = ACCUM;
                default: state_nxt = state;
            endcase
        end
    end

    // Bin and period counters; bin keeps running outside ACCUM to hold PN phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len <= '0;
            bin <= '0;
            per <= '0;
        end else if (i_start) begin
            if (len_ok) len <= i_pnseq_length;
            bin <= '0;
            per <= '0;
        end else if (state != IDLE && i_tvalid) begin
            bin <= last_bin ? 9'd0 : bin + 9'd1;
            if (state != ACCUM)  per <= '0;
            else if (last_bin)   per <= per + 1'b1;
        end
    end

    // ---- stage p1: magnitude of the accepted sample, its bin, and first-period flag
    // Accumulate valid flag for the write stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= acc_take;
    end

    // Accumulate data path registers (no reset needed).
    always_ff @(posedge clk) begin
        mag_p1   <= mag_calc($signed(i_tdata[31:16]), $signed(i_tdata[15:0]));
        bin_p1   <= bin[AW-1:0];
        first_p1 <= (per == '0);
    end

    // ---- stage p2: read-modify-write into the accumulator RAM
    // Single registered read port shared by accumulate and dump; held during output stalls.
    always_ff @(posedge clk) begin
        if (state != DUMP || dump_adv) ram_rd_p1 <= ram[rd_addr];
        if (vld_p1) ram[bin_p1] <= first_p1 ? ACC_W'(mag_p1)
                                            : ram_rd_p1 + ACC_W'(mag_p1);
    end

    // Dump sequencer: drain wait, read pointer, read-valid stage and output valid/last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain    <= '0;
            rd_ptr   <= '0;
            rq_vld   <= 1'b0;
            rq_last  <= 1'b0;
            o_tvalid <= 1'b0;
            o_tlast  <= 1'b0;
        end else if (i_start || state != DUMP) begin
            drain    <= '0;
            rd_ptr   <= '0;
            rq_vld   <= 1'b0;
            rq_last  <= 1'b0;
            o_tvalid <= 1'b0;
            o_tlast  <= 1'b0;
        end else begin
            if (drain != 2'd2) drain <= drain + 2'd1;
            if (dump_adv) begin
                o_tvalid <= rq_vld;
                o_tlast  <= rq_last;
                rq_vld   <= dump_go;
                rq_last  <= (rd_ptr == len - 9'd1);
                if (dump_go) rd_ptr <= rd_ptr + 9'd1;
            end
        end
    end

    // ---- output stage: scaled accumulator word
    // Output data register; loads only when a valid read word moves forward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                                o_tdata <= '0;
        else if (state == DUMP && !i_start && dump_adv && rq_vld) o_tdata <= avg_scale(ram_rd_p1);
    end

`ifdef CORR_MAG_PEAK_EN
    logic [8:0]  beat_idx, run_idx;
    logic [31:0] run_val;
    logic        new_max;

    assign new_max = (beat_idx == 9'd0) || (o_tdata > run_val);

    // Running maximum over dump beats; a strict compare keeps the lowest bin on ties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_idx   <= '0;
            run_idx    <= '0;
            run_val    <= '0;
            o_peak_val <= '0;
            o_peak_idx <= '0;
        end else if (i_start || state != DUMP) begin
            beat_idx <= '0;
        end else if (dump_hs) begin
            beat_idx <= beat_idx + 9'd1;
            if (new_max) begin
                run_val <= o_tdata;
                run_idx <= beat_idx;
            end
            if (o_tlast) begin
                o_peak_val <= new_max ? o_tdata : run_val;
                o_peak_idx <= new_max ? beat_idx : run_idx;
            end
        end
    end
`endif

endmodule
